// File: rtl/sdcard_clk_ctrl.sv
// rtl/sdcard_clk_ctrl.sv - glitch-safe SD clock sequencing, idle gating and power-down control
// Every divider change runs stop -> settle -> load -> settle -> optional calibration.
module sdcard_clk_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter logic [15:0] ID_DIV        = 16'd124,
  parameter logic [15:0] DS_DIV        = 16'd1,
  parameter logic [15:0] HS_DIV        = 16'd0,
  parameter logic [15:0] MAX_DIV       = 16'h00C8,
  parameter logic [15:0] CAL_TIMEOUT   = 16'd1024
) (
  input  logic        PCLK_i,
  input  logic        PRESETn_i,
  input  logic        req_valid_i,
  input  logic [1:0]  req_mode_i,
  input  logic [15:0] req_div_i,
  input  logic        req_cal_i,
  output logic        req_ready_o,
  output logic        req_done_o,
  output logic        req_err_o,
  input  logic        gate_req_i,
  input  logic        bus_busy_i,
  input  logic        power_down_i,
  output logic        clk_enable_o,
  output logic [15:0] clk_divider_o,
  output logic        cal_start_o,
  input  logic        cal_done_i,
  input  logic [15:0] cal_result_i,
  output logic [15:0] cal_result_o,
  output logic        clk_running_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_STOP      = 3'd1,
    S_LOAD      = 3'd2,
    S_SETTLE_ON = 3'd3,
    S_CAL       = 3'd4,
    S_RUN       = 3'd5,
    S_GATED     = 3'd6
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t      state, state_d;
  logic [7:0]  settle_cnt, settle_cnt_d;
  logic [15:0] cal_cnt, cal_cnt_d;
  logic [15:0] target, target_d;
  logic        cal_req, cal_req_d;
  logic        en_d, cal_start_d, done_d, err_d, running_d;
  logic [15:0] div_d, cres_d;
  logic [15:0] req_target;
  logic        req_bad, accept, in_flight;

  assign state_o     = state;
  assign req_ready_o = ((state == S_OFF) || (state == S_RUN) || (state == S_GATED)) && !power_down_i;
  assign accept      = req_valid_i && req_ready_o;
  assign req_bad     = (req_mode_i == 2'd3) && (req_div_i > MAX_DIV);
  assign in_flight   = (state == S_STOP) || (state == S_LOAD) || (state == S_SETTLE_ON) || (state == S_CAL);

  always_comb begin
    case (req_mode_i)
      2'd0:    req_target = ID_DIV;
      2'd1:    req_target = DS_DIV;
      2'd2:    req_target = HS_DIV;
      default: req_target = req_div_i;
    endcase
  end

  always_comb begin
    state_d      = state;
    settle_cnt_d = settle_cnt;
    cal_cnt_d    = cal_cnt;
    target_d     = target;
    cal_req_d    = cal_req;
    en_d         = clk_enable_o;
    div_d        = clk_divider_o;
    cres_d       = cal_result_o;
    cal_start_d  = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    if (power_down_i) begin
      state_d = S_OFF;
      en_d    = 1'b0;
      err_d   = in_flight;
    end else begin
      case (state)
        S_OFF, S_RUN, S_GATED: begin
          if (accept) begin
            if (req_bad) begin
              err_d = 1'b1;
            end else begin
              target_d     = req_target;
              cal_req_d    = req_cal_i;
              state_d      = S_STOP;
              en_d         = 1'b0;
              settle_cnt_d = SETTLE_LOAD;
            end
          end else if (state == S_RUN && gate_req_i && !bus_busy_i) begin
            state_d = S_GATED;
            en_d    = 1'b0;
          end else if (state == S_GATED && (!gate_req_i || bus_busy_i)) begin
            state_d = S_RUN;
            en_d    = 1'b1;
          end
        end
        S_STOP: begin
          if (settle_cnt == 8'd0) state_d = S_LOAD;
          else settle_cnt_d = settle_cnt - 8'd1;
        end
        S_LOAD: begin
          div_d        = target;
          en_d         = 1'b1;
          state_d      = S_SETTLE_ON;
          settle_cnt_d = SETTLE_LOAD;
        end
        S_SETTLE_ON: begin
          if (settle_cnt != 8'd0) begin
            settle_cnt_d = settle_cnt - 8'd1;
          end else if (cal_req) begin
            state_d     = S_CAL;
            cal_start_d = 1'b1;
            cal_cnt_d   = 16'd0;
          end else begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end
        end
        S_CAL: begin
          if (cal_done_i) begin
            cres_d  = cal_result_i;
            state_d = S_RUN;
            done_d  = 1'b1;
          end else if (cal_cnt == CAL_TIMEOUT - 16'd1) begin
            // Timeout keeps the freshly loaded divider; only the result is missing.
            state_d = S_RUN;
            err_d   = 1'b1;
          end else begin
            cal_cnt_d = cal_cnt + 16'd1;
          end
        end
        default: begin
          state_d = S_OFF;
          en_d    = 1'b0;
        end
      endcase
    end
    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      state         <= S_OFF;
      settle_cnt    <= 8'd0;
      cal_cnt       <= 16'd0;
      target        <= ID_DIV;
      cal_req       <= 1'b0;
      clk_enable_o  <= 1'b0;
      clk_divider_o <= ID_DIV;
      cal_start_o   <= 1'b0;
      req_done_o    <= 1'b0;
      req_err_o     <= 1'b0;
      cal_result_o  <= 16'd0;
      clk_running_o <= 1'b0;
    end else begin
      state         <= state_d;
      settle_cnt    <= settle_cnt_d;
      cal_cnt       <= cal_cnt_d;
      target        <= target_d;
      cal_req       <= cal_req_d;
      clk_enable_o  <= en_d;
      clk_divider_o <= div_d;
      cal_start_o   <= cal_start_d;
      req_done_o    <= done_d;
      req_err_o     <= err_d;
      cal_result_o  <= cres_d;
      clk_running_o <= running_d;
    end
  end

endmodule

// File: tb/tb_sdcard_clk_ctrl.sv
// tb/tb_sdcard_clk_ctrl.sv - scoreboard bench for sdcard_clk_ctrl
module tb_sdcard_clk_ctrl;

  localparam int          SETTLE  = 8;
  localparam logic [15:0] ID_DIV  = 16'd124;
  localparam logic [15:0] DS_DIV  = 16'd1;
  localparam logic [15:0] HS_DIV  = 16'd0;
  localparam logic [15:0] MAX_DIV = 16'h00C8;
  localparam int          CAL_TO  = 1024;

  logic        PCLK_i = 1'b0;
  logic        PRESETn_i;
  logic        req_valid_i, req_cal_i, req_ready_o, req_done_o, req_err_o;
  logic [1:0]  req_mode_i;
  logic [15:0] req_div_i;
  logic        gate_req_i, bus_busy_i, power_down_i;
  logic        clk_enable_o, cal_start_o, cal_done_i, clk_running_o;
  logic [15:0] clk_divider_o, cal_result_i, cal_result_o;
  logic [2:0]  state_o;

  sdcard_clk_ctrl dut (
    .PCLK_i(PCLK_i), .PRESETn_i(PRESETn_i),
    .req_valid_i(req_valid_i), .req_mode_i(req_mode_i), .req_div_i(req_div_i),
    .req_cal_i(req_cal_i), .req_ready_o(req_ready_o), .req_done_o(req_done_o),
    .req_err_o(req_err_o), .gate_req_i(gate_req_i), .bus_busy_i(bus_busy_i),
    .power_down_i(power_down_i), .clk_enable_o(clk_enable_o),
    .clk_divider_o(clk_divider_o), .cal_start_o(cal_start_o), .cal_done_i(cal_done_i),
    .cal_result_i(cal_result_i), .cal_result_o(cal_result_o),
    .clk_running_o(clk_running_o), .state_o(state_o)
  );

  always #5 PCLK_i = ~PCLK_i;

  typedef struct {
    bit          is_err;
    int          cyc;
    logic [15:0] div;
    logic [15:0] cres;
    logic [2:0]  st;
    bit          en;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          cal_delay = 0;
  logic [15:0] cal_val = 16'd0;
  int          exp_cs_cyc = -1;
  // Reference view of the bus: current divider, last result, clock running or off.
  logic [15:0] m_div = ID_DIV;
  logic [15:0] m_cres = 16'd0;
  bit          m_run = 1'b0;

  always @(posedge PCLK_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge PCLK_i) begin
    if (PRESETn_i && (req_done_o || req_err_o)) begin
      chk("done_err_exclusive", {31'd0, req_done_o & req_err_o}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {31'd0, req_err_o}, 32'd2);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind_err", {31'd0, req_err_o}, {31'd0, e.is_err});
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_divider", {16'd0, clk_divider_o}, {16'd0, e.div});
        chk("pulse_cal_result", {16'd0, cal_result_o}, {16'd0, e.cres});
        chk("pulse_state", {29'd0, state_o}, {29'd0, e.st});
        chk("pulse_enable", {31'd0, clk_enable_o}, {31'd0, e.en});
        chk("pulse_running", {31'd0, clk_running_o}, {31'd0, e.st == 3'd5});
      end
    end
  end

  initial begin
    forever begin
      @(negedge PCLK_i);
      if (cal_start_o) begin
        int d;
        chk("cal_start_cycle", cyc, exp_cs_cyc);
        d = cal_delay;
        @(negedge PCLK_i);
        chk("cal_start_width", {31'd0, cal_start_o}, 32'd0);
        if (d > 0) begin
          repeat (d - 1) @(posedge PCLK_i);
          #1;
          cal_done_i   = 1'b1;
          cal_result_i = cal_val;
          @(posedge PCLK_i);
          #1 cal_done_i = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] mode, input logic [15:0] div, input bit cal,
                       input int delay, input logic [15:0] val);
    int          k;
    logic [15:0] tgt;
    k = cyc;
    tgt = (mode == 2'd0) ? ID_DIV : (mode == 2'd1) ? DS_DIV : (mode == 2'd2) ? HS_DIV : div;
    if (mode == 2'd3 && div > MAX_DIV) begin
      sb.push_back('{1'b1, k + 1, m_div, m_cres, m_run ? 3'd5 : 3'd0, m_run});
    end else begin
      m_div = tgt;
      m_run = 1'b1;
      if (!cal) begin
        sb.push_back('{1'b0, k + 2*SETTLE + 2, m_div, m_cres, 3'd5, 1'b1});
      end else begin
        exp_cs_cyc = k + 2*SETTLE + 2;
        if (delay > 0) begin
          m_cres = val;
          sb.push_back('{1'b0, k + 2*SETTLE + 3 + delay, m_div, m_cres, 3'd5, 1'b1});
        end else begin
          sb.push_back('{1'b1, k + 2*SETTLE + 2 + CAL_TO, m_div, m_cres, 3'd5, 1'b1});
        end
      end
    end
    cal_delay   = delay;
    cal_val     = val;
    req_mode_i  = mode;
    req_div_i   = div;
    req_cal_i   = cal;
    req_valid_i = 1'b1;
    @(posedge PCLK_i);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic drain(input int lim);
    for (int i = 0; i < lim && sb.size() != 0; i++) @(posedge PCLK_i);
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(posedge PCLK_i);
    #1;
  endtask

  initial begin
    PRESETn_i = 1'b0; req_valid_i = 1'b0; req_mode_i = 2'd0; req_div_i = 16'd0;
    req_cal_i = 1'b0; gate_req_i = 1'b0; bus_busy_i = 1'b0; power_down_i = 1'b0;
    cal_done_i = 1'b0; cal_result_i = 16'd0;
    repeat (3) @(posedge PCLK_i);
    #1 PRESETn_i = 1'b1;
    @(posedge PCLK_i); #1;
    chk("rst_state", {29'd0, state_o}, 32'd0);
    chk("rst_enable", {31'd0, clk_enable_o}, 32'd0);
    chk("rst_divider", {16'd0, clk_divider_o}, {16'd0, ID_DIV});
    chk("rst_cal_result", {16'd0, cal_result_o}, 32'd0);
    chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_pulses", {28'd0, cal_start_o, req_done_o, req_err_o, clk_running_o}, 32'd0);

    issue(2'd2, 16'd0, 1'b0, 0, 16'd0);
    repeat (4) @(posedge PCLK_i); #1;
    chk("stop_state", {29'd0, state_o}, 32'd1);
    chk("stop_enable", {31'd0, clk_enable_o}, 32'd0);
    drain(100);

    issue(2'd3, 16'h00C9, 1'b0, 0, 16'd0);
    drain(20);
    issue(2'd3, 16'h00C8, 1'b0, 0, 16'd0);
    drain(100);
    issue(2'd1, 16'd0, 1'b1, 5, 16'h0002);
    drain(100);
    issue(2'd1, 16'd0, 1'b1, 0, 16'd0);
    drain(CAL_TO + 100);

    gate_req_i = 1'b1;
    @(posedge PCLK_i); #1;
    chk("gate_state", {29'd0, state_o}, 32'd6);
    chk("gate_enable", {31'd0, clk_enable_o}, 32'd0);
    bus_busy_i = 1'b1;
    @(posedge PCLK_i); #1;
    chk("ungate_state", {29'd0, state_o}, 32'd5);
    chk("ungate_enable", {31'd0, clk_enable_o}, 32'd1);
    bus_busy_i = 1'b0;
    @(posedge PCLK_i); #1;
    chk("regate_state", {29'd0, state_o}, 32'd6);
    issue(2'd2, 16'd0, 1'b0, 0, 16'd0);
    chk("gated_req_state", {29'd0, state_o}, 32'd1);
    gate_req_i = 1'b0;
    drain(100);
    gate_req_i = 1'b1;
    issue(2'd0, 16'd0, 1'b0, 0, 16'd0);
    chk("run_req_gate_state", {29'd0, state_o}, 32'd1);
    gate_req_i = 1'b0;
    drain(100);

    for (int n = 0; n < 24; n++) begin
      logic [1:0]  mode;
      logic [15:0] div;
      bit          cal;
      mode = 2'($urandom_range(0, 3));
      div  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(201, 65535)) : 16'($urandom_range(0, 200));
      cal  = ($urandom_range(0, 1) == 1);
      issue(mode, div, cal, $urandom_range(1, 30), 16'($urandom));
      drain(200);
    end

    begin
      int k;
      k = cyc;
      issue(2'd1, 16'd0, 1'b0, 0, 16'd0);
      void'(sb.pop_back());
      m_run = 1'b0;
      sb.push_back('{1'b1, k + 13, m_div, m_cres, 3'd0, 1'b0});
      repeat (11) @(posedge PCLK_i); #1;
      chk("pd_in_settle_on", {29'd0, state_o}, 32'd3);
      power_down_i = 1'b1;
      repeat (3) @(posedge PCLK_i); #1;
      chk("pd_ready", {31'd0, req_ready_o}, 32'd0);
      chk("pd_state", {29'd0, state_o}, 32'd0);
      req_valid_i = 1'b1; req_mode_i = 2'd2; req_cal_i = 1'b0;
      repeat (2) @(posedge PCLK_i); #1;
      req_valid_i = 1'b0;
      chk("pd_held_off", {29'd0, state_o}, 32'd0);
      power_down_i = 1'b0;
      #1 chk("pd_release_ready", {31'd0, req_ready_o}, 32'd1);
      drain(20);
    end

    issue(2'd2, 16'd0, 1'b0, 0, 16'd0);
    drain(100);

    issue(2'd0, 16'd0, 1'b1, 0, 16'd0);
    repeat (22) @(posedge PCLK_i); #1;
    chk("rst_mid_cal_state_before", {29'd0, state_o}, 32'd4);
    PRESETn_i = 1'b0;
    sb.delete();
    m_div = ID_DIV; m_cres = 16'd0; m_run = 1'b0;
    #1;
    chk("rst_mid_state", {29'd0, state_o}, 32'd0);
    chk("rst_mid_enable", {31'd0, clk_enable_o}, 32'd0);
    chk("rst_mid_divider", {16'd0, clk_divider_o}, {16'd0, ID_DIV});
    chk("rst_mid_cal_result", {16'd0, cal_result_o}, 32'd0);
    chk("rst_mid_pulses", {28'd0, cal_start_o, req_done_o, req_err_o, clk_running_o}, 32'd0);
    @(posedge PCLK_i); #1 PRESETn_i = 1'b1;
    repeat (5) @(posedge PCLK_i); #1;
    chk("rst_mid_after", {29'd0, state_o}, 32'd0);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sdcard_clk_ctrl.md
# sdcard_clk_ctrl

Sequencing controller for `sdcard_clock_generator`. It accepts SD bus-speed change requests from the command engine and drives the generator's `clk_enable`, `clk_divider` and `cal_start` inputs. Every frequency switch is glitch-safe: stop the clock, settle, load the new divider, restart, settle, then optionally calibrate. It also gates the SD clock while the bus is idle and forces the clock off on power-down.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 8: PCLK cycles held after clock stop and after clock restart (1..255).
- `ID_DIV`, default 16'd124: identification-mode divider (400 kHz at 100 MHz PCLK; f = PCLK/(2·(div+1))).
- `DS_DIV`, default 16'd1: default-speed divider (25 MHz).
- `HS_DIV`, default 16'd0: high-speed divider (50 MHz).
- `MAX_DIV`, default 16'h00C8: largest legal custom divider.
- `CAL_TIMEOUT`, default 16'd1024: PCLK cycles to wait for `cal_done_i`.

Ports:
- `PCLK_i`: in, 1, clock.
- `PRESETn_i`: in, 1, reset; asynchronous, active-low.
- `req_valid_i`: in, 1, speed-change request valid.
- `req_mode_i`: in, 2, requested mode: 0 ID, 1 DS, 2 HS, 3 custom.
- `req_div_i`: in, 16, custom divider; used only when mode is 3.
- `req_cal_i`: in, 1, run calibration after the switch.
- `req_ready_o`: out, 1, request can be accepted this cycle.
- `req_done_o`: out, 1, one-cycle pulse when a switch completes successfully.
- `req_err_o`: out, 1, one-cycle pulse on reject, abort or calibration timeout.
- `gate_req_i`: in, 1, permission to gate the clock while idle.
- `bus_busy_i`: in, 1, command/data transfer in progress.
- `power_down_i`: in, 1, force clock off.
- `clk_enable_o`: out, 1, to generator `clk_enable`.
- `clk_divider_o`: out, 16, to generator `clk_divider`.
- `cal_start_o`: out, 1, one-cycle pulse to generator `cal_start`.
- `cal_done_i`: in, 1, generator calibration done.
- `cal_result_i`: in, 16, generator calibration result.
- `cal_result_o`: out, 16, last captured calibration result.
- `clk_running_o`: out, 1, high in RUN only.
- `state_o`: out, 3, current state encoding.

## Operation
- States and encodings: OFF=0, STOP=1, LOAD=2, SETTLE_ON=3, CAL=4, RUN=5, GATED=6.
- Reset values:
  - State is OFF.
  - `clk_enable_o`=0, `clk_divider_o`=ID_DIV.
  - `cal_start_o`, `req_done_o`, `req_err_o`, `clk_running_o` are 0.
  - `cal_result_o`=0.
  - `req_ready_o`=1 (it is combinational).
- `req_ready_o` = state ∈ {OFF, RUN, GATED} and `!power_down_i`.
- Accepting a request (`req_valid_i && req_ready_o`):
  - The mode maps to a target divider: ID_DIV, DS_DIV, HS_DIV, or `req_div_i`.
  - If mode is 3 and `req_div_i > MAX_DIV`: reject. Pulse `req_err_o` next cycle; state and outputs are unchanged.
  - Otherwise latch the target and `req_cal_i`, go to STOP, and drive `clk_enable_o`←0.
- STOP:
  - Counter loads SETTLE_CYCLES-1 on entry and decrements each cycle.
  - At 0, go to LOAD.
- LOAD: `clk_divider_o`←target, `clk_enable_o`←1, go to SETTLE_ON.
- SETTLE_ON:
  - Counts SETTLE_CYCLES the same way as STOP.
  - At 0: if latched cal is set, pulse `cal_start_o` and go to CAL. Otherwise go to RUN and pulse `req_done_o`.
- CAL:
  - A 16-bit timeout counter starts at 0.
  - On `cal_done_i`: capture `cal_result_i` into `cal_result_o`, go to RUN, pulse `req_done_o`.
  - If the counter reaches CAL_TIMEOUT-1 without `cal_done_i`: go to RUN, pulse `req_err_o`. The divider is retained.
- RUN:
  - If `gate_req_i && !bus_busy_i` and no accepted request: go to GATED, `clk_enable_o`←0.
- GATED:
  - On `!gate_req_i || bus_busy_i`: go to RUN, `clk_enable_o`←1.
  - An accepted request goes to STOP; the clock is already off and the divider is unchanged until LOAD.
- Power-down, from any state with `power_down_i`=1:
  - Next state is OFF, `clk_enable_o`←0.
  - If the state was STOP, LOAD, SETTLE_ON or CAL, pulse `req_err_o`; the in-flight request is aborted.
  - `clk_divider_o` holds its value.
  - OFF is left only by an accepted request.
- Priority, highest first: power_down > calibration done/timeout > request > gating.
- A request accepted in OFF follows the full STOP sequence; this keeps latency uniform.

## Timing
- All outputs are registered except `req_ready_o`.
- Latency from request accept to `req_done_o`, no calibration: 2·SETTLE_CYCLES+2 cycles (default 18).
- With calibration: 2·SETTLE_CYCLES+2 plus cycles to `cal_done_i`, plus 1.
- `cal_start_o` asserts exactly 1 cycle, in the cycle CAL is entered.
- Gate on/off: `clk_enable_o` changes 1 cycle after the condition is sampled.
- `req_done_o` and `req_err_o` are never high in the same cycle.
- Asynchronous reset mid-sequence returns to OFF immediately with reset values. No done/err pulse is produced.

## Test plan
- Reset, then request mode 2 with no calibration → STOP 8 cycles, then `clk_divider_o`=0, `clk_enable_o`=1, `req_done_o` at accept+18, state RUN.
- Request mode 3 with `req_div_i`=16'h00C9 → `req_err_o` pulse, state and divider unchanged; 16'h00C8 → accepted.
- Request mode 1 with calibration, `cal_done_i` 5 cycles after `cal_start_o`, `cal_result_i`=16'h0002 → `cal_result_o`=2, `req_done_o`; no `cal_done_i` → `req_err_o` at 1024 cycles, state RUN.
- In RUN, `gate_req_i`=1 and `bus_busy_i`=0 → GATED, `clk_enable_o`=0; raise `bus_busy_i` → RUN, `clk_enable_o`=1 next cycle; same-cycle request plus gate → STOP.
- Assert `power_down_i` during SETTLE_ON → OFF, `req_err_o` pulse, `req_ready_o`=0 until released.
- Assert `PRESETn_i` low during CAL → all outputs at reset values, state OFF.
